hysteresis_threshold: RTL and testbench

- Final Canny stage; consumes the raster-order 11-bit magnitude stream from non_max_suppression (nms_magnitude/nms_valid).
- Classifies each pixel as STRONG, WEAK or NONE against two runtime thresholds.
- Emits an 8-bit binary edge image (255/0) in raster order.
- A WEAK pixel is promoted to an edge if any of its 8 neighbours is STRONG. This is single-pass, with no iterative propagation. A 3x3 window is built from two line buffers of 2-bit classes.

---
 rtl/hysteresis_threshold_if.sv | 24 ++
 rtl/hysteresis_threshold.sv | 261 ++++++++++++++++++++++++++
 tb/tb_hysteresis_threshold.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hysteresis_threshold_if.sv
// Pixel-stream bundle between the non-max-suppression stage and the
// hysteresis stage: magnitude input, runtime thresholds and edge output.
interface hysteresis_threshold_if #(
  parameter int MAG_W = 11
);
  logic [MAG_W-1:0] nms_magnitude;
  logic             nms_valid;
  logic [MAG_W-1:0] low_thresh;
  logic [MAG_W-1:0] high_thresh;
  logic [7:0]       edge_pixel;
  logic             edge_valid;
  logic             frame_done;
  logic             drop_err;

  modport master (
    output nms_magnitude, nms_valid, low_thresh, high_thresh,
    input  edge_pixel, edge_valid, frame_done, drop_err
  );

  modport slave (
    input  nms_magnitude, nms_valid, low_thresh, high_thresh,
    output edge_pixel, edge_valid, frame_done, drop_err
  );
endinterface

// File: rtl/hysteresis_threshold.sv
// Canny hysteresis: classifies magnitudes as STRONG/WEAK/NONE and promotes a
// WEAK pixel when any 8-neighbour is STRONG, using a 3x3 window over 2-bit classes.
module hysteresis_threshold #(
  parameter int IMG_W = 512,
  parameter int IMG_H = 512,
  parameter int MAG_W = 11
) (
  input logic                   clk,
  input logic                   rst,
  hysteresis_threshold_if.slave bus
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int CNT_W = $clog2(NPIX + 1);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  localparam logic [CNT_W-1:0] CNT_FILL_LAST = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(NPIX - 1);
  localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_RUN   = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    C_NONE   = 2'd0,
    C_WEAK   = 2'd1,
    C_STRONG = 2'd2
  } cls_t;

  // STRONG wins over WEAK even when the thresholds are inverted.
  function automatic cls_t classify(input logic [MAG_W-1:0] mag,
                                    input logic [MAG_W-1:0] lo,
                                    input logic [MAG_W-1:0] hi);
    cls_t c;
    if (mag >= hi) begin
      c = C_STRONG;
    end else if (mag >= lo) begin
      c = C_WEAK;
    end else begin
      c = C_NONE;
    end
    return c;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [COL_W-1:0] in_col_q, in_col_d;
  logic [COL_W-1:0] out_col_q, out_col_d;
  logic [ROW_W-1:0] out_row_q, out_row_d;
  logic [MAG_W-1:0] low_q, low_d;
  logic [MAG_W-1:0] high_q, high_d;

  // Window columns: m1 is the column entered one advance ago, m2 two ago.
  cls_t m1_top_q, m1_mid_q, m1_bot_q, m1_top_d, m1_mid_d, m1_bot_d;
  cls_t m2_top_q, m2_mid_q, m2_bot_q, m2_top_d, m2_mid_d, m2_bot_d;

  cls_t lb0_q [IMG_W];
  cls_t lb1_q [IMG_W];

  logic [7:0] edge_pixel_q, edge_pixel_d;
  logic       edge_valid_q, edge_valid_d;
  logic       frame_done_q, frame_done_d;
  logic       drop_err_q, drop_err_d;

  logic [MAG_W-1:0] lo_s, hi_s;
  logic             accept_s, adv_s, emit_s, edge_s, strong_nb_s;
  logic             top_ok_s, bot_ok_s, left_ok_s, right_ok_s;
  logic [COL_W-1:0] rd_col_s, col_inc_s;
  cls_t             new_cls_s, top_new_s, mid_new_s;

  // Front end: effective thresholds, advance control, line-buffer read, classification.
  always_comb begin
    if (state_q == S_IDLE) begin
      lo_s     = bus.low_thresh;
      hi_s     = bus.high_thresh;
      rd_col_s = '0;
    end else begin
      lo_s     = low_q;
      hi_s     = high_q;
      rd_col_s = in_col_q;
    end
    accept_s  = bus.nms_valid && (state_q != S_FLUSH);
    adv_s     = accept_s || (state_q == S_FLUSH);
    emit_s    = (accept_s && (state_q == S_RUN)) || (state_q == S_FLUSH);
    col_inc_s = (in_col_q == COL_LAST) ? '0 : in_col_q + COL_W'(1);
    top_new_s = lb1_q[rd_col_s];
    mid_new_s = lb0_q[rd_col_s];
    if (state_q == S_FLUSH) begin
      new_cls_s = C_NONE;
    end else begin
      new_cls_s = classify(bus.nms_magnitude, lo_s, hi_s);
    end
  end

  // Decision for the centre (m1 middle); out-of-image neighbours masked by output position.
  always_comb begin
    top_ok_s    = (out_row_q != '0);
    bot_ok_s    = (out_row_q != ROW_LAST);
    left_ok_s   = (out_col_q != '0);
    right_ok_s  = (out_col_q != COL_LAST);
    strong_nb_s = (top_ok_s && left_ok_s  && (m2_top_q  == C_STRONG)) ||
                  (top_ok_s               && (m1_top_q  == C_STRONG)) ||
                  (top_ok_s && right_ok_s && (top_new_s == C_STRONG)) ||
                  (left_ok_s              && (m2_mid_q  == C_STRONG)) ||
                  (right_ok_s             && (mid_new_s == C_STRONG)) ||
                  (bot_ok_s && left_ok_s  && (m2_bot_q  == C_STRONG)) ||
                  (bot_ok_s               && (m1_bot_q  == C_STRONG)) ||
                  (bot_ok_s && right_ok_s && (new_cls_s == C_STRONG));
    edge_s      = (m1_mid_q == C_STRONG) || ((m1_mid_q == C_WEAK) && strong_nb_s);
  end

  // Next-state logic: FSM, counters, window shift and output registers.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    in_col_d     = in_col_q;
    out_col_d    = out_col_q;
    out_row_d    = out_row_q;
    low_d        = low_q;
    high_d       = high_q;
    m1_top_d     = m1_top_q;
    m1_mid_d     = m1_mid_q;
    m1_bot_d     = m1_bot_q;
    m2_top_d     = m2_top_q;
    m2_mid_d     = m2_mid_q;
    m2_bot_d     = m2_bot_q;
    edge_pixel_d = 8'd0;
    edge_valid_d = 1'b0;
    frame_done_d = 1'b0;
    drop_err_d   = 1'b0;

    if (adv_s) begin
      m2_top_d = m1_top_q;
      m2_mid_d = m1_mid_q;
      m2_bot_d = m1_bot_q;
      m1_top_d = top_new_s;
      m1_mid_d = mid_new_s;
      m1_bot_d = new_cls_s;
      in_col_d = (state_q == S_IDLE) ? COL_W'(1) : col_inc_s;
    end else begin
      in_col_d = in_col_q;
    end

    if (emit_s) begin
      edge_valid_d = 1'b1;
      edge_pixel_d = edge_s ? 8'd255 : 8'd0;
      if (out_col_q == COL_LAST) begin
        out_col_d = '0;
        out_row_d = (out_row_q == ROW_LAST) ? '0 : out_row_q + ROW_W'(1);
      end else begin
        out_col_d = out_col_q + COL_W'(1);
      end
    end else begin
      edge_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          low_d     = bus.low_thresh;
          high_d    = bus.high_thresh;
          cnt_d     = CNT_W'(1);
          out_col_d = '0;
          out_row_d = '0;
          state_d   = S_FILL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        if (accept_s) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = (cnt_q == CNT_FILL_LAST) ? S_RUN : S_FILL;
        end else begin
          state_d = S_FILL;
        end
      end
      S_RUN: begin
        if (accept_s) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = (cnt_q == CNT_LAST) ? S_FLUSH : S_RUN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FLUSH: begin
        drop_err_d = bus.nms_valid;
        if ((out_row_q == ROW_LAST) && (out_col_q == COL_LAST)) begin
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          state_d = S_FLUSH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counter, window and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      in_col_q     <= '0;
      out_col_q    <= '0;
      out_row_q    <= '0;
      low_q        <= '0;
      high_q       <= '0;
      m1_top_q     <= C_NONE;
      m1_mid_q     <= C_NONE;
      m1_bot_q     <= C_NONE;
      m2_top_q     <= C_NONE;
      m2_mid_q     <= C_NONE;
      m2_bot_q     <= C_NONE;
      edge_pixel_q <= 8'd0;
      edge_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      drop_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      in_col_q     <= in_col_d;
      out_col_q    <= out_col_d;
      out_row_q    <= out_row_d;
      low_q        <= low_d;
      high_q       <= high_d;
      m1_top_q     <= m1_top_d;
      m1_mid_q     <= m1_mid_d;
      m1_bot_q     <= m1_bot_d;
      m2_top_q     <= m2_top_d;
      m2_mid_q     <= m2_mid_d;
      m2_bot_q     <= m2_bot_d;
      edge_pixel_q <= edge_pixel_d;
      edge_valid_q <= edge_valid_d;
      frame_done_q <= frame_done_d;
      drop_err_q   <= drop_err_d;
    end
  end

  // Line buffers: lb0 holds the row above the incoming column, lb1 the row above that.
  always_ff @(posedge clk) begin
    if (adv_s) begin
      lb1_q[rd_col_s] <= mid_new_s;
      lb0_q[rd_col_s] <= new_cls_s;
    end
  end

  assign bus.edge_pixel = edge_pixel_q;
  assign bus.edge_valid = edge_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.drop_err   = drop_err_q;

endmodule

// File: tb/tb_hysteresis_threshold.sv
// Bench for hysteresis_threshold on an 8x4 image: directed scenarios plus
// randomized frames checked against a 2-D neighbourhood reference model.
module tb_hysteresis_threshold;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int MW = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hysteresis_threshold_if #(.MAG_W(MW)) bus ();
  hysteresis_threshold #(.IMG_W(W), .IMG_H(H), .MAG_W(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int fm [N];
  int lo_m = 100;
  int hi_m = 200;

  logic [7:0] out_q [$];
  int out_cyc_q [$];
  int in_cyc_q [$];
  int fd_count = 0;
  int fd_at = 0;
  int fd_with_valid = 0;
  int drop_count = 0;
  int ncyc = 0;

  // Passive monitor, sampling on the falling edge.
  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (bus.nms_valid === 1'b1) in_cyc_q.push_back(ncyc);
    if (bus.edge_valid === 1'b1) begin
      out_q.push_back(bus.edge_pixel);
      out_cyc_q.push_back(ncyc);
    end
    if (bus.frame_done === 1'b1) begin
      fd_count = fd_count + 1;
      fd_at = out_q.size();
      fd_with_valid = (bus.edge_valid === 1'b1) ? 1 : 0;
    end
    if (bus.drop_err === 1'b1) drop_count = drop_count + 1;
  end

  function automatic int cls_of(int v, int lo, int hi);
    if (v >= hi) return 2;
    if (v >= lo) return 1;
    return 0;
  endfunction

  // Reference: apply the STRONG / WEAK-with-STRONG-neighbour rule on the 2-D frame.
  function automatic logic [7:0] ref_pix(int r, int c);
    int cc;
    bit s;
    cc = cls_of(fm[r*W + c], lo_m, hi_m);
    s = 1'b0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W) begin
          if (cls_of(fm[(r+dr)*W + c + dc], lo_m, hi_m) == 2) s = 1'b1;
        end
      end
    end
    if (cc == 2) return 8'd255;
    if (cc == 1 && s) return 8'd255;
    return 8'd0;
  endfunction

  task automatic clear_frame();
    for (int i = 0; i < N; i++) fm[i] = 0;
  endtask

  // gap: 0 none, 1 every other cycle, 2 random; tail: valid cycles driven into FLUSH.
  task automatic run_frame(input int gap, input int tail, input int thr_at, output bit to);
    int fd0;
    fd0 = fd_count;
    for (int i = 0; i < N; i++) begin
      bus.nms_magnitude = 11'(fm[i]);
      bus.nms_valid = 1'b1;
      if (i == thr_at) bus.high_thresh = 11'd300;
      @(posedge clk); #1;
      if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
        bus.nms_valid = 1'b0;
        bus.nms_magnitude = 11'($urandom_range(0, 2047));
        @(posedge clk); #1;
      end
    end
    bus.nms_valid = 1'b0;
    if (tail > 0) begin
      bus.nms_valid = 1'b1;
      bus.nms_magnitude = 11'd250;
      repeat (tail) @(posedge clk);
      #1;
      bus.nms_valid = 1'b0;
    end
    to = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (fd_count != fd0) begin
        to = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic set_thr(input int lo, input int hi);
    lo_m = lo;
    hi_m = hi;
    bus.low_thresh = 11'(lo);
    bus.high_thresh = 11'(hi);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.edge_valid !== 1'b0) begin n_bad++; $display("FAIL reset_edge_valid: got %b want 0", bus.edge_valid); end
    n_cmp++; if (bus.edge_pixel !== 8'd0) begin n_bad++; $display("FAIL reset_edge_pixel: got %0d want 0", bus.edge_pixel); end
    n_cmp++; if (bus.frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done: got %b want 0", bus.frame_done); end
    n_cmp++; if (bus.drop_err !== 1'b0) begin n_bad++; $display("FAIL reset_drop_err: got %b want 0", bus.drop_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_all_zero();
    int ob, ib, db, fb;
    bit to;
    logic [7:0] act;
    clear_frame(); set_thr(100, 200);
    ob = out_q.size(); ib = in_cyc_q.size(); db = drop_count; fb = fd_count;
    run_frame(0, 0, -1, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL zero_timeout: got %0d want 0", to); end
    n_cmp++; if (out_q.size() - ob !== N) begin n_bad++; $display("FAIL zero_count: got %0d want %0d", out_q.size() - ob, N); end
    for (int i = 0; i < N; i++) begin
      act = (ob + i < out_q.size()) ? out_q[ob + i] : 8'hxx;
      n_cmp++; if (act !== 8'd0) begin n_bad++; $display("FAIL zero_pix[%0d]: got %0d want 0", i, act); end
    end
    if (out_cyc_q.size() > ob && in_cyc_q.size() > ib + 9) begin
      n_cmp++; if (out_cyc_q[ob] !== in_cyc_q[ib + 9] + 1) begin n_bad++; $display("FAIL zero_latency: first out cyc %0d want %0d", out_cyc_q[ob], in_cyc_q[ib + 9] + 1); end
    end else begin
      n_cmp++; n_bad++; $display("FAIL zero_latency: no samples recorded");
    end
    n_cmp++; if (fd_count - fb !== 1 || fd_at !== ob + N || fd_with_valid !== 1) begin n_bad++; $display("FAIL zero_frame_done: cnt %0d at %0d valid %0d want 1 %0d 1", fd_count - fb, fd_at - ob, fd_with_valid, N); end
    n_cmp++; if (drop_count - db !== 0) begin n_bad++; $display("FAIL zero_drop: got %0d want 0", drop_count - db); end
  endtask

  task automatic test_pattern(input string name, input int gap, input int tail, input int thr_at, input int want_drops);
    int ob, db;
    bit to;
    logic [7:0] act, exp;
    ob = out_q.size(); db = drop_count;
    run_frame(gap, tail, thr_at, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL %s_timeout: got %0d want 0", name, to); end
    n_cmp++; if (out_q.size() - ob !== N) begin n_bad++; $display("FAIL %s_count: got %0d want %0d", name, out_q.size() - ob, N); end
    for (int i = 0; i < N; i++) begin
      exp = ref_pix(i / W, i % W);
      act = (ob + i < out_q.size()) ? out_q[ob + i] : 8'hxx;
      n_cmp++; if (act !== exp) begin n_bad++; $display("FAIL %s_pix(%0d,%0d): got %0d want %0d", name, i / W, i % W, act, exp); end
    end
    n_cmp++; if (drop_count - db !== want_drops) begin n_bad++; $display("FAIL %s_drops: got %0d want %0d", name, drop_count - db, want_drops); end
  endtask

  task automatic test_single_strong();
    clear_frame(); set_thr(100, 200);
    fm[1*W + 3] = 250;
    test_pattern("single", 0, 0, -1, 0);
  endtask

  task automatic test_no_chain();
    clear_frame(); set_thr(100, 200);
    fm[1*W + 3] = 150; fm[2*W + 4] = 250;
    test_pattern("adjacent", 0, 0, -1, 0);
    clear_frame();
    fm[1*W + 3] = 150; fm[3*W + 5] = 250;
    test_pattern("far", 0, 0, -1, 0);
  endtask

  task automatic test_boundary();
    clear_frame(); set_thr(100, 200);
    fm[1*W + 7] = 250; fm[2*W + 0] = 150;
    test_pattern("rowwrap", 0, 0, -1, 0);
    clear_frame();
    fm[0] = 150; fm[1*W + 1] = 250;
    test_pattern("corner", 0, 0, -1, 0);
    clear_frame();
    fm[3*W + 7] = 250; fm[3*W + 6] = 150; fm[0] = 250; fm[1] = 180;
    test_pattern("edges", 0, 0, -1, 0);
  endtask

  task automatic test_gapped();
    clear_frame(); set_thr(100, 200);
    fm[1*W + 3] = 250;
    test_pattern("gapped", 1, 0, -1, 0);
  endtask

  task automatic test_flush_drop();
    clear_frame(); set_thr(100, 200);
    fm[1*W + 3] = 250; fm[1*W + 4] = 120;
    test_pattern("flushdrop", 0, 3, -1, 3);
  endtask

  task automatic test_thresh_change();
    clear_frame(); set_thr(100, 200);
    fm[1*W + 3] = 250; fm[1*W + 2] = 150;
    test_pattern("thrchange", 0, 0, 5, 0);
    bus.high_thresh = 11'd200;
  endtask

  task automatic test_reset_midframe();
    int sz;
    clear_frame(); set_thr(100, 200);
    fm[1*W + 3] = 250;
    for (int i = 0; i < 20; i++) begin
      bus.nms_magnitude = 11'(fm[i]);
      bus.nms_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.nms_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.edge_valid !== 1'b0 || bus.edge_pixel !== 8'd0) begin n_bad++; $display("FAIL midrst_outputs: valid %b pix %0d want 0 0", bus.edge_valid, bus.edge_pixel); end
    sz = out_q.size();
    repeat (20) @(negedge clk);
    n_cmp++; if (out_q.size() !== sz) begin n_bad++; $display("FAIL midrst_quiet: got %0d extra outputs want 0", out_q.size() - sz); end
    @(posedge clk); #1;
    test_pattern("afterrst", 0, 0, -1, 0);
  endtask

  task automatic test_back_to_back();
    clear_frame(); set_thr(100, 200);
    fm[1*W + 3] = 150; fm[2*W + 4] = 250;
    test_pattern("b2b_a", 0, 0, -1, 0);
    clear_frame();
    fm[0] = 220; fm[1] = 130; fm[3*W + 7] = 140; fm[2*W + 6] = 201;
    test_pattern("b2b_b", 0, 0, -1, 0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < N; i++) fm[i] = $urandom_range(0, 400);
      if (f == 2) set_thr(250, 120);
      else set_thr($urandom_range(0, 300), $urandom_range(0, 300));
      test_pattern("random", 2, 0, -1, 0);
    end
  endtask

  initial begin
    bus.nms_valid = 1'b0;
    bus.nms_magnitude = 11'd0;
    bus.low_thresh = 11'd100;
    bus.high_thresh = 11'd200;
    test_reset();
    test_all_zero();
    test_single_strong();
    test_no_chain();
    test_boundary();
    test_gapped();
    test_flush_drop();
    test_thresh_change();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
